// File: rtl/vmem_text_writer.sv
// Text-mode writer: turns ASCII key events into video character RAM writes at
// a hardware cursor, handles Enter/Backspace/wrap, and clears the screen with
// a one-cell-per-cycle sweep.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a key event or a clear request
//   S_CLEAR | sweeping BLANK over every cell, ascending, one per cycle
//   S_HOME  | sweep done; park cursor at (0,0) and return to S_IDLE
module vmem_text_writer #(
  parameter int          COLS     = 70,
  parameter int          ROWS     = 30,
  parameter int          ADDR_W   = 12,
  parameter int          END_MODE = 0,
  parameter logic [7:0]  BLANK    = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [7:0]                key_char,
  input  logic                      up,
  input  logic                      clear_req,
  output logic                      ready,
  output logic                      vm_we,
  output logic [ADDR_W-1:0]         vm_addr,
  output logic [7:0]                vm_data,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [ADDR_W-1:0]         cur_addr
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam bit                WRAP_HOME = (END_MODE == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_HOME  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [COL_W-1:0]    col_n;
  logic [ROW_W-1:0]    row_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                we_n;
  logic [ADDR_W-1:0]   waddr_n;
  logic [7:0]          wdata_n;
  logic [ADDR_W-1:0]   clr_addr, clr_n;

  logic                is_print, is_enter, is_bs, last_row;
  logic [7:0]          case_char;

  assign ready = (state == S_IDLE);

  // Character classification and optional upper-casing of a-z.
  always_comb begin
    is_print  = (key_char >= 8'h20) && (key_char <= 8'h7E);
    is_enter  = (key_char == 8'h0D);
    is_bs     = (key_char == 8'h08);
    last_row  = (cur_row == ROW_LAST);
    case_char = key_char;
    if (up && (key_char >= 8'h61) && (key_char <= 8'h7A))
      case_char = key_char - 8'h20;
  end

  // Next-state, next-cursor and next RAM-port values.
  always_comb begin
    state_n = state;
    col_n   = cur_col;
    row_n   = cur_row;
    addr_n  = cur_addr;
    we_n    = 1'b0;
    waddr_n = vm_addr;
    wdata_n = vm_data;
    clr_n   = clr_addr;

    case (state)
      S_IDLE: begin
        if (clear_req) begin
          // A clear request wins over a coincident key, which is dropped.
          state_n = S_CLEAR;
          clr_n   = '0;
        end else if (key_valid) begin
          if (is_print) begin
            we_n    = 1'b1;
            waddr_n = cur_addr;
            wdata_n = case_char;
            if (cur_col != COL_LAST) begin
              col_n  = cur_col + 1'b1;
              addr_n = cur_addr + 1'b1;
            end else if (!last_row) begin
              col_n  = '0;
              row_n  = cur_row + 1'b1;
              addr_n = cur_addr + 1'b1;
            end else if (WRAP_HOME) begin
              col_n  = '0;
              row_n  = '0;
              addr_n = '0;
            end else begin
              // Cursor is left alone; HOME parks it once the sweep ends.
              state_n = S_CLEAR;
              clr_n   = '0;
            end
          end else if (is_enter) begin
            if (!last_row) begin
              col_n  = '0;
              row_n  = cur_row + 1'b1;
              addr_n = cur_addr - ADDR_W'(cur_col) + COLS_A;
            end else if (WRAP_HOME) begin
              col_n  = '0;
              row_n  = '0;
              addr_n = '0;
            end else begin
              state_n = S_CLEAR;
              clr_n   = '0;
            end
          end else if (is_bs) begin
            // Linear address steps back by one in both the in-row and
            // row-crossing cases, so no multiply is needed.
            if (cur_col != '0) begin
              col_n   = cur_col - 1'b1;
              addr_n  = cur_addr - 1'b1;
              we_n    = 1'b1;
              waddr_n = cur_addr - 1'b1;
              wdata_n = BLANK;
            end else if (cur_row != '0) begin
              col_n   = COL_LAST;
              row_n   = cur_row - 1'b1;
              addr_n  = cur_addr - 1'b1;
              we_n    = 1'b1;
              waddr_n = cur_addr - 1'b1;
              wdata_n = BLANK;
            end
          end
        end
      end
      S_CLEAR: begin
        we_n    = 1'b1;
        waddr_n = clr_addr;
        wdata_n = BLANK;
        clr_n   = clr_addr + 1'b1;
        if (clr_addr == ADDR_LAST)
          state_n = S_HOME;
      end
      S_HOME: begin
        col_n   = '0;
        row_n   = '0;
        addr_n  = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, cursor and registered RAM-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cur_col  <= '0;
      cur_row  <= '0;
      cur_addr <= '0;
      vm_we    <= 1'b0;
      vm_addr  <= '0;
      vm_data  <= '0;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      cur_col  <= col_n;
      cur_row  <= row_n;
      cur_addr <= addr_n;
      vm_we    <= we_n;
      vm_addr  <= waddr_n;
      vm_data  <= wdata_n;
      clr_addr <= clr_n;
    end
  end

endmodule
